vec_accumulator: RTL

VEC_ACCUMULATOR -- requirements
Module: vec_accumulator

---
 rtl/vecmac_pkg.sv | 13 +
 rtl/vec_result_reg.sv | 69 ++++++
 rtl/vec_accumulator.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/vecmac_pkg.sv
// Shared encoding and default widths for the vector multiply-accumulate back end.
package vecmac_pkg;

  localparam int DEF_INW  = 19;
  localparam int DEF_ACCW = 32;
  localparam int DEF_LENW = 16;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

endpackage

// File: rtl/vec_result_reg.sv
// Single-entry result holding register with valid/ready handshake and a sticky
// overflow flag raised when a completed result arrives while the entry is still held.
module vec_result_reg
  import vecmac_pkg::*;
#(
  parameter int ACCW = DEF_ACCW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [ACCW-1:0] load_acc_i,
  input  logic            load_sat_i,
  input  logic            out_ready_i,
  output logic            out_valid_o,
  output logic [ACCW-1:0] out_acc_o,
  output logic            out_sat_o,
  output logic            ovf_o
);

  logic            valid_q, valid_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic            sat_q, sat_d;
  logic            ovf_q, ovf_d;
  logic            accept;
  logic            can_load;

  // The entry is free if empty or if the consumer takes it on this very edge.
  assign accept   = valid_q && out_ready_i;
  assign can_load = !valid_q || out_ready_i;

  always_comb begin
    valid_d = valid_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    ovf_d   = ovf_q;
    if (load_i && can_load) begin
      valid_d = 1'b1;
      acc_d   = load_acc_i;
      sat_d   = load_sat_i;
    end else begin
      if (load_i) begin
        ovf_d = 1'b1;
      end
      if (accept) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_acc_o   = acc_q;
  assign out_sat_o   = sat_q;
  assign ovf_o       = ovf_q;

endmodule

// File: rtl/vec_accumulator.sv
// Saturating dot-product accumulator: sums a programmed number of adder-tree beats
// and hands each finished vector to a single-entry result register.
module vec_accumulator
  import vecmac_pkg::*;
#(
  parameter int INW  = DEF_INW,
  parameter int ACCW = DEF_ACCW,
  parameter int LENW = DEF_LENW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_start,
  input  logic [LENW-1:0] cfg_len,
  input  logic            cfg_cont,
  input  logic            in_valid,
  input  logic [INW-1:0]  in_sum,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] out_acc,
  output logic            out_sat,
  output logic            busy,
  output logic            err_ovf
);

  state_e          state_q, state_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [LENW:0]   cnt_q, cnt_d;
  logic [LENW-1:0] len_q, len_d;
  logic            cont_q, cont_d;
  logic            sat_q, sat_d;

  logic [ACCW-1:0] base_acc;
  logic [LENW:0]   base_cnt;
  logic            base_sat;
  logic [LENW-1:0] len_eff;
  logic            cont_eff;
  logic            run;
  logic            beat;
  logic [ACCW:0]   sum_wide;
  logic [ACCW-1:0] acc_upd;
  logic            sat_upd;
  logic [LENW:0]   cnt_upd;
  logic            done;

  // A start pulse replaces the running vector's context in the same cycle, so a
  // coincident beat lands on a fresh accumulator as beat 1.
  always_comb begin
    base_acc = acc_q;
    base_cnt = cnt_q;
    base_sat = sat_q;
    len_eff  = len_q;
    cont_eff = cont_q;
    if (cfg_start) begin
      base_acc = '0;
      base_cnt = '0;
      base_sat = 1'b0;
      len_eff  = (cfg_len == '0) ? LENW'(1) : cfg_len;
      cont_eff = cfg_cont;
    end
  end

  always_comb begin
    sum_wide = {1'b0, base_acc} + (ACCW+1)'(in_sum);
    acc_upd  = sum_wide[ACCW] ? {ACCW{1'b1}} : sum_wide[ACCW-1:0];
    sat_upd  = base_sat | sum_wide[ACCW];
    cnt_upd  = base_cnt + (LENW+1)'(1);
  end

  always_comb begin
    run = 1'b0;
    unique case (state_q)
      IDLE:    run = cfg_start;
      ACC:     run = 1'b1;
      default: run = 1'b0;
    endcase
  end

  assign beat = run && in_valid;
  assign done = beat && (cnt_upd == {1'b0, len_eff});

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    cont_d  = cont_q;
    sat_d   = sat_q;
    if (run) begin
      state_d = ACC;
      len_d   = len_eff;
      cont_d  = cont_eff;
      acc_d   = base_acc;
      cnt_d   = base_cnt;
      sat_d   = base_sat;
      if (done) begin
        // Continuous mode rolls straight into the next vector with no gap cycle.
        acc_d   = '0;
        cnt_d   = '0;
        sat_d   = 1'b0;
        state_d = cont_eff ? ACC : IDLE;
      end else if (beat) begin
        acc_d = acc_upd;
        cnt_d = cnt_upd;
        sat_d = sat_upd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      cont_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      cont_q  <= cont_d;
      sat_q   <= sat_d;
    end
  end

  assign busy = (state_q == ACC);

  vec_result_reg #(
    .ACCW(ACCW)
  ) u_result (
    .clk         (clk),
    .rst         (rst),
    .load_i      (done),
    .load_acc_i  (acc_upd),
    .load_sat_i  (sat_upd),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_acc_o   (out_acc),
    .out_sat_o   (out_sat),
    .ovf_o       (err_ovf)
  );

endmodule
